multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing the LEGv8 multi-cycle datapath (PC, IR, regfile, ALU, memories).
//  Decodes the latched 11-bit opcode and emits per-state datapath strobes, including the 2-bit ALUOp.
//  ALUOp feeds the existing ALU control decoder in 3_execute.
//  Sits in 2_decode beside the register file; one instruction in flight, no pipelining.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles a memory state waits for its ready before FAULT (1..255)
//  CNT_W         32  width of perf counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   11     instruction[31:21] from IR, valid from DECODE onward
//  zero         in   1      ALU zero flag, sampled in BRANCH
//  imem_ready   in   1      instruction memory has data / accepts fetch
//  dmem_ready   in   1      data memory completed read/write this cycle
//  imem_read    out  1      instruction fetch request
//  ir_write     out  1      latch instruction into IR
//  pc_write     out  1      unconditional PC update
//  pc_src       out  2      00 ALU result (PC+4), 01 branch target reg, 10 jump target
//  alu_src_a    out  1      0 PC, 1 reg A
//  alu_src_b    out  2      00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  ALUOp        out  2      00 add, 01 pass-B, 10 R-type funct decode
//  reg2loc      out  1      select Rt (1) vs Rm (0) as read reg 2
//  dmem_read    out  1      data memory read request
//  dmem_write   out  1      data memory write request
//  reg_write    out  1      register file write enable
//  mem_to_reg   out  1      writeback source: 1 memory data, 0 ALUOut
//  fault        out  1      sticky: illegal opcode or memory timeout
//  state_dbg    out  4      current state encoding
//  cycle_cnt    out  CNT_W  cycles since reset (MC_PERF_CNT_EN)
//  instr_cnt    out  CNT_W  retired instructions (MC_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset: state=S_RESET, all outputs 0, wait counter 0. First edge after rst_n rises -> FETCH.
//  - Outputs: pure function of state, except pc_write in BRANCH = zero.
//  - FETCH: imem_read=1, alu_src_a=0, alu_src_b=01, ALUOp=00.
//    On imem_ready: ir_write=1, pc_write=1, pc_src=00 (same cycle) -> DECODE.
//    Otherwise hold.
//  - DECODE: alu_src_a=0, alu_src_b=11, ALUOp=00 (branch target precompute). Next state by opcode:
//    ADD/SUB/AND/ORR -> EXEC_R; LDUR 11111000010 / STUR 11111000000 -> ADDR (reg2loc=1 for STUR).
//    CBZ 10110100xxx -> BRANCH (reg2loc=1); B 000101xxxxx -> JUMP; anything else -> FAULT.
//  - EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=10 -> WB_R (reg_write=1, mem_to_reg=0) -> FETCH.
//  - ADDR: alu_src_a=1, alu_src_b=10, ALUOp=00 -> MEM_RD (LDUR) or MEM_WR (STUR).
//  - MEM_RD: dmem_read=1 held until dmem_ready -> WB_LD (reg_write=1, mem_to_reg=1) -> FETCH.
//  - MEM_WR: dmem_write=1 held until dmem_ready -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, pc_src=01, pc_write=zero -> FETCH.
//  - JUMP: pc_write=1, pc_src=10 -> FETCH.
//  - Minimum latency: R 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles, plus memory wait cycles.
//  - Wait counter:
//    cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle ready=0.
//    Reaching MEM_WAIT_MAX with ready still 0 -> FAULT.
//    Ready arriving in the same cycle the count hits MEM_WAIT_MAX wins (no fault).
//  - FAULT: all strobes 0, fault=1; stays until rst_n. Reset mid-operation aborts cleanly to S_RESET.
//  - Instruction retires on the last state: WB_R, WB_LD, MEM_WR+ready, BRANCH, JUMP.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//    cycle_cnt increments every cycle out of reset; instr_cnt increments on each retire.
//    Both wrap at 2^CNT_W, reset to 0, and freeze in FAULT.
//  MC_PERF_CNT_EN undefined: no counter flops; cycle_cnt/instr_cnt tied to 0.
// STRUCTURE
//  - definitions.vh: add state codes (`S_RESET..`S_FAULT, 4-bit) and `LDUR/`STUR/`CBZ/`B opcode
//    patterns beside the existing `ADD/`SUB/`AND/`ORR and ALU codes.
//  - One sub-module, op_class_decode: combinational opcode -> {R, LD, ST, CBZ, B, ILLEGAL} one-hot.
// TESTING
//  1. ADD opcode 10001011000, imem_ready=1 -> FETCH,DECODE,EXEC_R(ALUOp=10),WB_R(reg_write=1); 4 cycles.
//  2. LDUR, dmem_ready after 3 cycles -> dmem_read high 4 cycles, then WB_LD mem_to_reg=1; 8 cycles total.
//  3. CBZ with zero=1 -> pc_write=1, pc_src=01 in BRANCH; zero=0 -> pc_write=0; both back in FETCH.
//  4. Opcode 11111111111 -> FAULT after DECODE; fault=1 and all strobes 0 for 20+ cycles until rst_n.
//  5. MEM_WR with dmem_ready stuck 0 -> FAULT exactly 15 cycles after entry.
//     Ready on cycle 15 -> FETCH, no fault.
//  6. rst_n low mid MEM_RD -> outputs 0 immediately; FETCH one edge after release.
//     With MC_PERF_CNT_EN: 3 ADDs -> instr_cnt=3, cycle_cnt=13 (incl. S_RESET).

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the LEGv8 multi-cycle controller: state codes, opcode patterns,
// opcode-class bit positions and datapath select encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExecR  = 4'd3,
    StWbR    = 4'd4,
    StAddr   = 4'd5,
    StMemRd  = 4'd6,
    StWbLd   = 4'd7,
    StMemWr  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StFault  = 4'd11
  } state_e;

  localparam logic [10:0] OpcAdd  = 11'b10001011000;
  localparam logic [10:0] OpcSub  = 11'b11001011000;
  localparam logic [10:0] OpcAnd  = 11'b10001010000;
  localparam logic [10:0] OpcOrr  = 11'b10101010000;
  localparam logic [10:0] OpcLdur = 11'b11111000010;
  localparam logic [10:0] OpcStur = 11'b11111000000;
  // CBZ and B carry register/offset bits in the low opcode bits, so only prefixes match.
  localparam logic [7:0]  OpcCbz  = 8'b10110100;
  localparam logic [5:0]  OpcB    = 6'b000101;

  localparam int OcR       = 0;
  localparam int OcLd      = 1;
  localparam int OcSt      = 2;
  localparam int OcCbz     = 3;
  localparam int OcB       = 4;
  localparam int OcIllegal = 5;

  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] SrcBFour    = 2'b01;
  localparam logic [1:0] SrcBImm     = 2'b10;
  localparam logic [1:0] SrcBImmSh   = 2'b11;
  localparam logic [1:0] AluOpPassB  = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;

endpackage

// File: rtl/multicycle_control_op_class_decode.sv
// Combinational opcode classifier: exactly one bit of op_class_o is set for any opcode.
module multicycle_control_op_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] opcode_i,
  output logic [5:0]  op_class_o
);

  always_comb begin
    op_class_o = '0;
    if (opcode_i inside {OpcAdd, OpcSub, OpcAnd, OpcOrr}) begin
      op_class_o[OcR] = 1'b1;
    end else if (opcode_i == OpcLdur) begin
      op_class_o[OcLd] = 1'b1;
    end else if (opcode_i == OpcStur) begin
      op_class_o[OcSt] = 1'b1;
    end else if (opcode_i[10:3] == OpcCbz) begin
      op_class_o[OcCbz] = 1'b1;
    end else if (opcode_i[10:5] == OpcB) begin
      op_class_o[OcB] = 1'b1;
    end else begin
      op_class_o[OcIllegal] = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the LEGv8 multi-cycle datapath, with memory-wait timeout to FAULT.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_read,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp,
  output logic             reg2loc,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             fault,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [5:0] op_class;
  logic       mem_state, mem_ready, wait_hit;

  multicycle_control_op_class_decode u_op_class_decode (
    .opcode_i   (opcode),
    .op_class_o (op_class)
  );

  assign mem_state = state_q inside {StFetch, StMemRd, StMemWr};
  assign mem_ready = (state_q == StFetch) ? imem_ready : dmem_ready;
  // Ready in the same cycle as the last allowed wait still wins.
  assign wait_hit  = mem_state && !mem_ready && (wait_q == 8'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch: begin
        if (imem_ready)    state_d = StDecode;
        else if (wait_hit) state_d = StFault;
      end
      StDecode: begin
        unique case (1'b1)
          op_class[OcR]:                 state_d = StExecR;
          op_class[OcLd], op_class[OcSt]: state_d = StAddr;
          op_class[OcCbz]:               state_d = StBranch;
          op_class[OcB]:                 state_d = StJump;
          op_class[OcIllegal]:           state_d = StFault;
          default:                       state_d = StFault;
        endcase
      end
      StExecR:  state_d = StWbR;
      StWbR:    state_d = StFetch;
      StAddr:   state_d = op_class[OcLd] ? StMemRd : StMemWr;
      StMemRd: begin
        if (dmem_ready)    state_d = StWbLd;
        else if (wait_hit) state_d = StFault;
      end
      StWbLd:   state_d = StFetch;
      StMemWr: begin
        if (dmem_ready)    state_d = StFetch;
        else if (wait_hit) state_d = StFault;
      end
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StFault:  state_d = StFault;
      default:  state_d = StFault;
    endcase
  end

  // Any state change clears the wait count, which covers entry into every memory state.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_comb begin
    imem_read  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ALUOp      = 2'b00;
    reg2loc    = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_read = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = imem_ready;
        pc_write  = imem_ready;
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
        reg2loc   = op_class[OcSt] | op_class[OcCbz];
      end
      StExecR: begin
        alu_src_a = 1'b1;
        ALUOp     = AluOpFunct;
      end
      StWbR:    reg_write = 1'b1;
      StAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd:  dmem_read = 1'b1;
      StWbLd: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr:  dmem_write = 1'b1;
      StBranch: begin
        alu_src_a = 1'b1;
        ALUOp     = AluOpPassB;
        pc_src    = PcSrcBranch;
        pc_write  = zero;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PcSrcJump;
      end
      StFault:  fault = 1'b1;
      default:  ;
    endcase
  end

  assign state_dbg = state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
  logic             retire;

  assign retire = (state_q inside {StWbR, StWbLd, StBranch, StJump}) ||
                  (state_q == StMemWr && dmem_ready);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != StFault) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
      if (retire) instr_cnt_d = instr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class, memory timeouts,
// illegal opcodes and mid-operation reset, checking state and all strobes each cycle.
module tb_multicycle_control;

  // Strobe vector order: imem_read, ir_write, pc_write, pc_src[1:0], alu_src_a, alu_src_b[1:0],
  // ALUOp[1:0], reg2loc, dmem_read, dmem_write, reg_write, mem_to_reg, fault.
  localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_WB_R = 4'd4, S_ADDR = 4'd5, S_MEM_RD = 4'd6, S_WB_LD = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_FAULT = 4'd11;

  localparam logic [15:0] B_NONE = 16'h0000, B_FETCH = 16'hE100, B_DEC = 16'h0300;
  localparam logic [15:0] B_DEC_R2L = 16'h0320, B_EXEC_R = 16'h0480, B_WB_R = 16'h0004;
  localparam logic [15:0] B_ADDR = 16'h0600, B_MEM_RD = 16'h0010, B_WB_LD = 16'h0006;
  localparam logic [15:0] B_MEM_WR = 16'h0008, B_BR_T = 16'h2C40, B_BR_NT = 16'h0C40;
  localparam logic [15:0] B_JUMP = 16'h3000, B_FAULT = 16'h0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] opcode;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_read, ir_write, pc_write, alu_src_a, reg2loc;
  logic        dmem_read, dmem_write, reg_write, mem_to_reg, fault;
  logic [1:0]  pc_src, alu_src_b, ALUOp;
  logic [3:0]  state_dbg;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [15:0] strobes;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_read  (imem_read),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ALUOp      (ALUOp),
    .reg2loc    (reg2loc),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .fault      (fault),
    .state_dbg  (state_dbg),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  assign strobes = {imem_read, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, ALUOp,
                    reg2loc, dmem_read, dmem_write, reg_write, mem_to_reg, fault};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [3:0] st, input logic [15:0] sb);
    chk({tag, "_state"}, 32'(state_dbg), 32'(st));
    chk({tag, "_strobes"}, 32'(strobes), 32'(sb));
  endtask

  // Advance one clock edge, then check away from the edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [15:0] sb);
    @(posedge clk);
    #3;
    look(tag, st, sb);
  endtask

  initial begin
    rst_n      = 1'b0;
    opcode     = 11'b10001011000;
    zero       = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    #12;
    look("reset", S_RESET, B_NONE);
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    chk("reset_instr_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1;

    // Three R-type instructions: ADD, SUB, ORR.
    step("add_fetch", S_FETCH, B_FETCH);
    step("add_decode", S_DECODE, B_DEC);
    step("add_exec", S_EXEC_R, B_EXEC_R);
    step("add_wb", S_WB_R, B_WB_R);
    opcode = 11'b11001011000;
    step("sub_fetch", S_FETCH, B_FETCH);
    step("sub_decode", S_DECODE, B_DEC);
    step("sub_exec", S_EXEC_R, B_EXEC_R);
    step("sub_wb", S_WB_R, B_WB_R);
    opcode = 11'b10101010000;
    step("orr_fetch", S_FETCH, B_FETCH);
    step("orr_decode", S_DECODE, B_DEC);
    step("orr_exec", S_EXEC_R, B_EXEC_R);
    step("orr_wb", S_WB_R, B_WB_R);
    opcode = 11'b11111000010;
    step("ldur_fetch", S_FETCH, B_FETCH);
`ifdef MC_PERF_CNT_EN
    chk("perf_cycle_cnt", cycle_cnt, 32'd13);
    chk("perf_instr_cnt", instr_cnt, 32'd3);
`else
    chk("perf_cycle_cnt", cycle_cnt, 32'd0);
    chk("perf_instr_cnt", instr_cnt, 32'd0);
`endif

    // LDUR with dmem_ready on the fourth MEM_RD cycle.
    step("ldur_decode", S_DECODE, B_DEC);
    step("ldur_addr", S_ADDR, B_ADDR);
    step("ldur_mem1", S_MEM_RD, B_MEM_RD);
    step("ldur_mem2", S_MEM_RD, B_MEM_RD);
    step("ldur_mem3", S_MEM_RD, B_MEM_RD);
    step("ldur_mem4", S_MEM_RD, B_MEM_RD);
    dmem_ready = 1'b1;
    step("ldur_wb", S_WB_LD, B_WB_LD);
    dmem_ready = 1'b0;
    opcode = 11'b11111000000;
    step("stur_fetch", S_FETCH, B_FETCH);

    // STUR, ready on first MEM_WR cycle.
    step("stur_decode", S_DECODE, B_DEC_R2L);
    step("stur_addr", S_ADDR, B_ADDR);
    step("stur_mem", S_MEM_WR, B_MEM_WR);
    dmem_ready = 1'b1;
    opcode = 11'b10110100101;
    step("cbz_t_fetch", S_FETCH, B_FETCH);
    dmem_ready = 1'b0;

    // CBZ taken then not taken.
    step("cbz_t_decode", S_DECODE, B_DEC_R2L);
    zero = 1'b1;
    step("cbz_t_branch", S_BRANCH, B_BR_T);
    step("cbz_nt_fetch", S_FETCH, B_FETCH);
    step("cbz_nt_decode", S_DECODE, B_DEC_R2L);
    zero = 1'b0;
    step("cbz_nt_branch", S_BRANCH, B_BR_NT);
    opcode = 11'b00010111010;
    step("b_fetch", S_FETCH, B_FETCH);
    step("b_decode", S_DECODE, B_DEC);
    step("b_jump", S_JUMP, B_JUMP);
    opcode = 11'b11111000000;
    step("stw_fetch", S_FETCH, B_FETCH);

    // STUR whose ready arrives on the 15th wait cycle: no fault.
    step("stw_decode", S_DECODE, B_DEC_R2L);
    step("stw_addr", S_ADDR, B_ADDR);
    for (int i = 1; i <= 15; i++) step("stw_mem", S_MEM_WR, B_MEM_WR);
    dmem_ready = 1'b1;
    step("stw_fetch_after", S_FETCH, B_FETCH);
    dmem_ready = 1'b0;

    // STUR with ready stuck low: FAULT 15 cycles after entry, sticky.
    step("sto_decode", S_DECODE, B_DEC_R2L);
    step("sto_addr", S_ADDR, B_ADDR);
    for (int i = 1; i <= 15; i++) step("sto_mem", S_MEM_WR, B_MEM_WR);
    step("sto_fault", S_FAULT, B_FAULT);
    for (int i = 0; i < 5; i++) step("sto_fault_hold", S_FAULT, B_FAULT);

    // Reset out of FAULT, then an illegal opcode.
    rst_n = 1'b0;
    #1;
    look("fault_reset", S_RESET, B_NONE);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    opcode = 11'b11111111111;
    step("ill_fetch", S_FETCH, B_FETCH);
    step("ill_decode", S_DECODE, B_DEC);
    for (int i = 0; i < 22; i++) step("ill_fault", S_FAULT, B_FAULT);
    rst_n = 1'b0;
    #1;
    look("ill_reset", S_RESET, B_NONE);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    opcode = 11'b11111000010;

    // Reset asserted in the middle of MEM_RD.
    step("abort_fetch", S_FETCH, B_FETCH);
    step("abort_decode", S_DECODE, B_DEC);
    step("abort_addr", S_ADDR, B_ADDR);
    step("abort_mem", S_MEM_RD, B_MEM_RD);
    rst_n = 1'b0;
    #1;
    look("abort_reset", S_RESET, B_NONE);
    @(posedge clk);
    #3;
    look("abort_hold", S_RESET, B_NONE);
    rst_n = 1'b1;
    step("abort_refetch", S_FETCH, B_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
